wb_write_arbiter: RTL and testbench
===================================

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register write-data width.
REQ-002 Parameter: ADDR_W, 5, register address width; the block is fixed at 32 registers.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 a_valid  in  1  single-cycle datapath write request.
REQ-007 a_rt  in  ADDR_W  destination register used when a_regdst=0.
REQ-008 a_rd  in  ADDR_W  destination register used when a_regdst=1.
REQ-009 a_regdst  in  1  destination select for requester A.
REQ-010 a_data  in  DATA_W  requester A write data.
REQ-011 a_ready  out  1  requester A is granted this cycle.
REQ-012 a_hazard  out  1  requester A's selected destination is pending from B.
REQ-013 b_valid  in  1  multicycle-unit write request.
REQ-014 b_dest  in  ADDR_W  requester B destination register.
REQ-015 b_data  in  DATA_W  requester B write data.
REQ-016 b_ready  out  1  requester B is granted this cycle.
REQ-017 b_issue  in  1  B has started an operation that will write b_issue_dest.
REQ-018 b_issue_dest  in  ADDR_W  destination of the issued B operation.
REQ-019 rf_we  out  1  register-file write enable, registered.
REQ-020 rf_waddr  out  ADDR_W  register-file write address, registered.
REQ-021 rf_wdata  out  DATA_W  register-file write data, registered.
REQ-022 pend  out  32  scoreboard; bit n is set while a B write to register n is outstanding.

Function
REQ-023 The selected A destination, a_dst, SHALL be a_rd when a_regdst=1 and a_rt otherwise.
REQ-024 a_hazard SHALL equal pend[a_dst], combinationally.
REQ-025 A SHALL be eligible when a_valid=1 and a_hazard=0; B SHALL be eligible when b_valid=1.
REQ-026 The FSM SHALL have two states: LAST_A (A won the last grant) and LAST_B (B won the last grant).
REQ-027 If only one requester is eligible, that requester SHALL be granted.
REQ-028 If both requesters are eligible, the grant SHALL go to B in LAST_A and to A in LAST_B.
REQ-029 a_ready and b_ready SHALL be combinational, mutually exclusive and never asserted without the matching valid.
REQ-030 A transfer SHALL occur when valid and ready are both 1 in the same cycle.
REQ-031 A grant to A SHALL move the FSM to LAST_A, a grant to B SHALL move it to LAST_B, and with no grant the state SHALL hold.
REQ-032 A transfer in cycle T SHALL drive rf_we=1 with the granted address and data during cycle T+1, giving one cycle of latency.
REQ-033 In any cycle following a cycle with no transfer, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their last values.
REQ-034 A transfer whose destination is register 0 SHALL complete the handshake and update the FSM, but SHALL drive rf_we=0.
REQ-035 b_issue=1 with b_issue_dest≠0 SHALL set pend[b_issue_dest] at the clock edge; b_issue_dest=0 SHALL leave pend unchanged.
REQ-036 A B transfer SHALL clear pend[b_dest] at the clock edge.
REQ-037 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-038 pend[0] SHALL always be 0.

Reset
REQ-039 While rst_n=0 at a rising edge, the block SHALL load state LAST_B, rf_we=0, rf_waddr=0, rf_wdata=0 and pend=0.
REQ-040 a_ready and b_ready SHALL be 0 while rst_n=0.
REQ-041 A request granted in the same cycle that reset is asserted SHALL be discarded, with no write in the following cycle.
REQ-042 The first tie after reset SHALL be granted to A.

Verification
REQ-043 Reset, then drive a_valid=1, a_regdst=1, a_rd=8, a_rt=9, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234.
REQ-044 Hold a_valid=1 and b_valid=1 continuously for 4 cycles after reset -> grants follow A, B, A, B, and rf_we=1 in each of the following 4 cycles.
REQ-045 Drive b_issue=1 with b_issue_dest=5, then a_valid=1, a_regdst=0, a_rt=5 -> a_hazard=1, a_ready=0 and pend[5]=1; after a B transfer with b_dest=5, pend[5]=0 and A is granted the next cycle.
REQ-046 Drive an A transfer with a_dst=0 -> a_ready=1 and next cycle rf_we=0; with b_issue_dest=0 -> pend stays 0.
REQ-047 In one cycle, drive a B transfer with b_dest=7 together with b_issue=1, b_issue_dest=7 -> pend[7] remains 1.
REQ-048 Assert rst_n=0 in a cycle where A is granted -> next cycle rf_we=0, pend=0, state LAST_B.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter between a single-cycle datapath (A) and a
// multicycle unit (B), with a pending-write scoreboard that stalls A on hazards.
module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rt,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic              a_regdst,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    output logic              a_hazard,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              b_issue,
    input  logic [ADDR_W-1:0] b_issue_dest,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       pend
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [31:0]       r_pend;
    logic [31:0]       w_pendNext;
    logic              r_rfWe;
    logic [ADDR_W-1:0] r_rfWaddr;
    logic [DATA_W-1:0] r_rfWdata;

    logic [ADDR_W-1:0] w_aDst;
    logic              w_aHazard;
    logic              w_aElig;
    logic              w_bElig;
    logic              w_aGrant;
    logic              w_bGrant;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_xferDst;
    logic [DATA_W-1:0] w_xferData;

    assign w_aDst    = a_regdst ? a_rd : a_rt;
    assign w_aHazard = r_pend[w_aDst];
    assign w_aElig   = a_valid && !w_aHazard;
    assign w_bElig   = b_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LAST_B;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_aGrant) begin
            w_nextState = LAST_A;
        end else if (w_bGrant) begin
            w_nextState = LAST_B;
        end
    end

    // On a tie, the requester that did not win last time gets the port.
    always_comb begin
        w_aGrant = 1'b0;
        w_bGrant = 1'b0;
        if (rst_n) begin
            if (w_aElig && w_bElig) begin
                if (r_state == LAST_A) begin
                    w_bGrant = 1'b1;
                end else begin
                    w_aGrant = 1'b1;
                end
            end else if (w_aElig) begin
                w_aGrant = 1'b1;
            end else if (w_bElig) begin
                w_bGrant = 1'b1;
            end
        end
    end

    assign w_xfer     = w_aGrant || w_bGrant;
    assign w_xferDst  = w_aGrant ? w_aDst : b_dest;
    assign w_xferData = w_aGrant ? a_data : b_data;

    // Register 0 is hardwired, so its writes complete the handshake without a write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
        end else begin
            r_rfWe <= w_xfer && (w_xferDst != '0);
            if (w_xfer) begin
                r_rfWaddr <= w_xferDst;
                r_rfWdata <= w_xferData;
            end
        end
    end

    // The set is applied after the clear so a same-cycle issue to the same register wins.
    always_comb begin
        w_pendNext = r_pend;
        if (w_bGrant) begin
            w_pendNext[b_dest] = 1'b0;
        end
        if (b_issue && (b_issue_dest != '0)) begin
            w_pendNext[b_issue_dest] = 1'b1;
        end
        w_pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    assign a_ready  = w_aGrant;
    assign b_ready  = w_bGrant;
    assign a_hazard = w_aHazard;
    assign rf_we    = r_rfWe;
    assign rf_waddr = r_rfWaddr;
    assign rf_wdata = r_rfWdata;
    assign pend     = r_pend;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: stimulus queues expected register-file
// writes, a negedge monitor pops and compares each write the DUT performs.
module tb_wb_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_rt;
    logic [4:0]  a_rd;
    logic        a_regdst;
    logic [31:0] a_data;
    logic        a_ready;
    logic        a_hazard;
    logic        b_valid;
    logic [4:0]  b_dest;
    logic [31:0] b_data;
    logic        b_ready;
    logic        b_issue;
    logic [4:0]  b_issue_dest;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } expWrite_t;

    expWrite_t expQ[$];
    int        assertCount = 0;
    int        failCount   = 0;

    wb_write_arbiter #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_rt        (a_rt),
        .a_rd        (a_rd),
        .a_regdst    (a_regdst),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .a_hazard    (a_hazard),
        .b_valid     (b_valid),
        .b_dest      (b_dest),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .b_issue     (b_issue),
        .b_issue_dest(b_issue_dest),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pend        (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge, returning mid-cycle.
    task automatic applyStimulus(
        input logic        rstN,
        input logic        aV,
        input logic [4:0]  aRt,
        input logic [4:0]  aRd,
        input logic        aRegdst,
        input logic [31:0] aData,
        input logic        bV,
        input logic [4:0]  bDest,
        input logic [31:0] bData,
        input logic        bIss,
        input logic [4:0]  bIssDest
    );
        @(posedge clk);
        #1;
        rst_n        = rstN;
        a_valid      = aV;
        a_rt         = aRt;
        a_rd         = aRd;
        a_regdst     = aRegdst;
        a_data       = aData;
        b_valid      = bV;
        b_dest       = bDest;
        b_data       = bData;
        b_issue      = bIss;
        b_issue_dest = bIssDest;
        #2;
    endtask

    task automatic applyIdle(input logic rstN);
        applyStimulus(rstN, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
        expWrite_t e;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Every asserted write strobe must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, expected no write at %0t",
                             rf_waddr, rf_wdata, $time);
                end else begin
                    expWrite_t e;
                    e = expQ.pop_front();
                    if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                        failCount++;
                        $display("[TB] FAIL write_match: got addr=%0d data=%h, expected addr=%0d data=%h at %0t",
                                 rf_waddr, rf_wdata, e.addr, e.data, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        a_valid      = 1'b0;
        a_rt         = '0;
        a_rd         = '0;
        a_regdst     = 1'b0;
        a_data       = '0;
        b_valid      = 1'b0;
        b_dest       = '0;
        b_data       = '0;
        b_issue      = 1'b0;
        b_issue_dest = '0;

        // Reset, with requests present that must be ignored
        applyIdle(0);
        applyIdle(0);
        applyStimulus(0, 1, 3, 4, 0, 32'hDEAD, 1, 6, 32'hBEEF, 1, 4);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_b_ready", b_ready, 0);
        checkOutput("rst_pend", pend, 0);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_rf_waddr", rf_waddr, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);

        // Single A write using rd as destination
        applyStimulus(1, 1, 9, 8, 1, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("a_only_ready", a_ready, 1);
        checkOutput("a_only_b_ready", b_ready, 0);
        checkOutput("a_only_hazard", a_hazard, 0);
        checkOutput("a_only_pend", pend, 0);
        expectWrite(8, 32'h1234);
        applyIdle(1);
        checkOutput("a_only_rf_we", rf_we, 1);
        checkOutput("a_only_rf_waddr", rf_waddr, 8);
        checkOutput("a_only_rf_wdata", rf_wdata, 32'h1234);
        applyIdle(1);
        checkOutput("idle_rf_we", rf_we, 0);
        checkOutput("idle_hold_waddr", rf_waddr, 8);

        // Continuous contention after reset alternates starting with A
        applyIdle(0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 32'hA0 + i, 1, 2, 32'hB0 + i, 0, 0);
            checkOutput("tie_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            checkOutput("tie_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
            if (i > 0) checkOutput("tie_rf_we", rf_we, 1);
            if (i % 2 == 0) expectWrite(1, 32'hA0 + i);
            else            expectWrite(2, 32'hB0 + i);
        end
        applyIdle(1);
        checkOutput("tie_last_rf_we", rf_we, 1);

        // Hazard: B issues to r5, A targets r5 via rt and stalls until B writes back
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        applyStimulus(1, 1, 5, 0, 0, 32'h55, 0, 0, 0, 0, 0);
        checkOutput("haz_a_hazard", a_hazard, 1);
        checkOutput("haz_a_ready", a_ready, 0);
        checkOutput("haz_pend", pend, 32'h20);
        applyStimulus(1, 1, 5, 0, 0, 32'h55, 1, 5, 32'h77, 0, 0);
        checkOutput("haz_b_a_hazard", a_hazard, 1);
        checkOutput("haz_b_a_ready", a_ready, 0);
        checkOutput("haz_b_ready", b_ready, 1);
        expectWrite(5, 32'h77);
        applyStimulus(1, 1, 5, 0, 0, 32'h55, 0, 0, 0, 0, 0);
        checkOutput("haz_clr_hazard", a_hazard, 0);
        checkOutput("haz_clr_a_ready", a_ready, 1);
        checkOutput("haz_clr_pend", pend, 0);
        expectWrite(5, 32'h55);
        applyIdle(1);
        checkOutput("haz_rf_we", rf_we, 1);
        applyIdle(1);
        checkOutput("hold_rf_we", rf_we, 0);
        checkOutput("hold_rf_waddr", rf_waddr, 5);
        checkOutput("hold_rf_wdata", rf_wdata, 32'h55);

        // Writes and issues targeting register 0
        applyStimulus(1, 1, 3, 0, 1, 32'h99, 0, 0, 0, 0, 0);
        checkOutput("r0_a_ready", a_ready, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("r0_rf_we", rf_we, 0);
        applyIdle(1);
        checkOutput("r0_pend", pend, 0);

        // Same-cycle set and clear of r7: set wins
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 7, 32'h7777, 1, 7);
        checkOutput("sc_b_ready", b_ready, 1);
        checkOutput("sc_pend_before", pend, 32'h80);
        expectWrite(7, 32'h7777);
        applyIdle(1);
        checkOutput("sc_pend_after", pend, 32'h80);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 7, 32'h7778, 0, 0);
        checkOutput("clr_b_ready", b_ready, 1);
        expectWrite(7, 32'h7778);
        applyIdle(1);
        checkOutput("clr_pend", pend, 0);

        // Reset while requests are pending discards them and restores LAST_B
        applyStimulus(1, 1, 10, 0, 0, 32'h10, 0, 0, 0, 1, 9);
        checkOutput("pre_rst_a_ready", a_ready, 1);
        expectWrite(10, 32'h10);
        applyStimulus(0, 1, 11, 0, 0, 32'h11, 1, 12, 32'h12, 0, 0);
        checkOutput("mid_rst_a_ready", a_ready, 0);
        checkOutput("mid_rst_b_ready", b_ready, 0);
        checkOutput("mid_rst_pend", pend, 32'h200);
        applyStimulus(1, 1, 13, 0, 0, 32'h13, 1, 14, 32'h14, 0, 0);
        checkOutput("post_rst_rf_we", rf_we, 0);
        checkOutput("post_rst_pend", pend, 0);
        checkOutput("post_rst_a_ready", a_ready, 1);
        checkOutput("post_rst_b_ready", b_ready, 0);
        expectWrite(13, 32'h13);
        applyIdle(1);
        checkOutput("post_rst_write_we", rf_we, 1);
        applyIdle(1);
        applyIdle(1);
        checkOutput("outstanding_writes", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
